// File: rtl/excp_pipe_pkg.sv
// Shared types and constants for the exception tracker: error-bit map,
// per-stage record and data-size encodings.
package excp_pipe_pkg;

    localparam int ERR_W  = 12;
    localparam int ADDR_W = 32;
    localparam int WA_W   = 5;

    localparam int ERR_RI     = 0;
    localparam int ERR_SYS    = 1;
    localparam int ERR_BP     = 2;
    localparam int ERR_ERET   = 3;
    localparam int ERR_ADES   = 4;
    localparam int ERR_ADEL_D = 5;
    localparam int ERR_ADEL_F = 6;
    localparam int ERR_OV     = 7;
    localparam int ERR_BD     = 9;
    localparam int ERR_MTC0   = 11;

    // Bits that mean "this instruction faults" (delay-slot and mtc0 markers excluded)
    localparam logic [ERR_W-1:0] ERR_FAULT_MASK = 12'h0FF;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [ERR_W-1:0]  err;
        logic [ADDR_W-1:0] badv;
        logic [WA_W-1:0]   wa;
    } exc_stage_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = |addr_lo;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // A bubble keeps the pc it had so pcM shows the last real instruction
    function automatic exc_stage_t make_bubble(input logic [ADDR_W-1:0] pc);
        exc_stage_t b;
        b       = '0;
        b.pc    = pc;
        return b;
    endfunction

endpackage

// File: rtl/excp_pipe_if.sv
// Pipeline-side signal bundle for the exception tracker.
interface excp_pipe_if;
    import excp_pipe_pkg::*;

    logic [ADDR_W-1:0] pcF;
    logic              validF;
    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              stallM;
    logic              cp0_flush;
    logic              riD;
    logic              sysD;
    logic              bpD;
    logic              eretD;
    logic              mtc0D;
    logic              branchD;
    logic [WA_W-1:0]   mtc0_waD;
    logic              ovE;
    logic              loadE;
    logic              storeE;
    logic [1:0]        sizeE;
    logic [ADDR_W-1:0] addrE;
    logic [ERR_W-1:0]  error;
    logic [ADDR_W-1:0] BadVaddr;
    logic [ADDR_W-1:0] pcM;
    logic [WA_W-1:0]   wa;
    logic              mem_killE;

    modport slave (
        input  pcF, validF, stallF, stallD, stallE, stallM, cp0_flush,
               riD, sysD, bpD, eretD, mtc0D, branchD, mtc0_waD,
               ovE, loadE, storeE, sizeE, addrE,
        output error, BadVaddr, pcM, wa, mem_killE
    );

    modport master (
        output pcF, validF, stallF, stallD, stallE, stallM, cp0_flush,
               riD, sysD, bpD, eretD, mtc0D, branchD, mtc0_waD,
               ovE, loadE, storeE, sizeE, addrE,
        input  error, BadVaddr, pcM, wa, mem_killE
    );

endinterface

// File: rtl/excp_pipe_stage_reg.sv
// One pipeline stage of exception state with hold, bubble insertion and flush.
module excp_stage_reg
    import excp_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       bubble_in,
    input  logic       flush,
    input  exc_stage_t st_in,
    output exc_stage_t st_out
);

    exc_stage_t st_q;
    exc_stage_t st_d;

    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = make_bubble(st_q.pc);
        end else if (!stall) begin
            if (bubble_in || !st_in.valid) begin
                st_d = make_bubble(st_q.pc);
            end else begin
                st_d = st_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign st_out = st_q;

endmodule

// File: rtl/excp_pipe.sv
// Exception tracker alongside F/D/E/M: collects fetch, decode and execute
// faults per instruction and presents the M-stage view to cp0.
module excp_pipe
    import excp_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    excp_pipe_if.slave  bus
);

    exc_stage_t d_stage, e_stage, m_stage;
    exc_stage_t d_in, e_in, m_in;

    logic bshadow_q, bshadow_d;
    logic d_adv;
    logic dec_mask, exe_mask;
    logic ld_mis, st_mis, exe_hit;

    // A bubble leaving D must not disturb the shadow of a branch ahead of it
    always_comb begin
        d_adv     = d_stage.valid & ~bus.stallD & ~bus.stallE;
        bshadow_d = bshadow_q;
        if (bus.cp0_flush) begin
            bshadow_d = 1'b0;
        end else if (d_adv) begin
            bshadow_d = bus.branchD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bshadow_q <= 1'b0;
        end else begin
            bshadow_q <= bshadow_d;
        end
    end

    always_comb begin
        d_in       = '0;
        d_in.valid = bus.validF;
        d_in.pc    = bus.pcF;
        if (bus.validF) begin
            d_in.err[ERR_BD] = bshadow_d;
            if (bus.pcF[1:0] != 2'b00) begin
                d_in.err[ERR_ADEL_F] = 1'b1;
                d_in.badv            = bus.pcF;
            end
        end
    end

    always_comb begin
        e_in     = d_stage;
        dec_mask = d_stage.err[ERR_ADEL_F];
        if (d_stage.valid && !dec_mask) begin
            e_in.err[ERR_RI]   = bus.riD;
            e_in.err[ERR_SYS]  = bus.sysD;
            e_in.err[ERR_BP]   = bus.bpD;
            e_in.err[ERR_ERET] = bus.eretD;
            if (bus.mtc0D) begin
                e_in.err[ERR_MTC0] = 1'b1;
                e_in.wa            = bus.mtc0_waD;
            end
        end
    end

    // Load takes precedence over store when both are flagged
    always_comb begin
        m_in     = e_stage;
        exe_mask = e_stage.err[ERR_ADEL_F] | (|e_stage.err[ERR_ERET:ERR_RI]);
        ld_mis   = bus.loadE & misaligned(bus.sizeE, bus.addrE[1:0]);
        st_mis   = ~bus.loadE & bus.storeE & misaligned(bus.sizeE, bus.addrE[1:0]);
        exe_hit  = e_stage.valid & ~exe_mask & (bus.ovE | ld_mis | st_mis);
        if (e_stage.valid && !exe_mask) begin
            m_in.err[ERR_OV] = bus.ovE;
            if (ld_mis) begin
                m_in.err[ERR_ADEL_D] = 1'b1;
                m_in.badv            = bus.addrE;
            end else if (st_mis) begin
                m_in.err[ERR_ADES] = 1'b1;
                m_in.badv          = bus.addrE;
            end
        end
    end

    excp_stage_reg u_stage_d (
        .clk       (clk),
        .reset     (reset),
        .stall     (bus.stallD),
        .bubble_in (bus.stallF),
        .flush     (bus.cp0_flush),
        .st_in     (d_in),
        .st_out    (d_stage)
    );

    excp_stage_reg u_stage_e (
        .clk       (clk),
        .reset     (reset),
        .stall     (bus.stallE),
        .bubble_in (bus.stallD),
        .flush     (bus.cp0_flush),
        .st_in     (e_in),
        .st_out    (e_stage)
    );

    excp_stage_reg u_stage_m (
        .clk       (clk),
        .reset     (reset),
        .stall     (bus.stallM),
        .bubble_in (bus.stallE),
        .flush     (bus.cp0_flush),
        .st_in     (m_in),
        .st_out    (m_stage)
    );

    assign bus.error     = m_stage.err;
    assign bus.BadVaddr  = m_stage.badv;
    assign bus.pcM       = m_stage.pc;
    assign bus.wa        = m_stage.wa;
    assign bus.mem_killE = (e_stage.valid & (|(e_stage.err & ERR_FAULT_MASK))) | exe_hit;

endmodule
